// File: rtl/board_reset_pkg.sv
// ============================================================================
// Module : board_reset_pkg
// Brief  : State encodings, fault codes and LED bit map for board_reset_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package board_reset_pkg;

    typedef enum logic [2:0] {
        ST_POR_WAIT = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_MEM_RST  = 3'd2,
        ST_CAL_WAIT = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam int c_CNT_W = 24;
    localparam int c_HB_W  = 25;

    localparam logic [1:0] c_FAULT_NONE        = 2'd0;
    localparam logic [1:0] c_FAULT_CAL_FAIL    = 2'd1;
    localparam logic [1:0] c_FAULT_CAL_TIMEOUT = 2'd2;
    localparam logic [1:0] c_FAULT_CAL_LOST    = 2'd3;

    localparam int c_LED_STATE_LSB = 0;
    localparam int c_LED_STATE_MSB = 2;
    localparam int c_LED_PLL       = 3;
    localparam int c_LED_CAL_OK    = 4;
    localparam int c_LED_CAL_FAIL  = 5;
    localparam int c_LED_FAULT     = 6;
    localparam int c_LED_HEARTBEAT = 7;

endpackage

`default_nettype wire

// File: rtl/sync_bits.sv
// ============================================================================
// Module : sync_bits
// Brief  : Width-parameterised multi-stage synchroniser, sync active-high reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_bits #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/board_reset_seq.sv
// ============================================================================
// Module : board_reset_seq
// Brief  : Board bring-up sequencer: global/memory/kernel resets and status LEDs.
//          Optional LED heartbeat in RUN: define BOARD_RESET_HEARTBEAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module board_reset_seq
    import board_reset_pkg::*;
#(
    parameter int NUM_MEM     = 2,
    parameter int POR_CYCLES  = 1024,
    parameter int HOLD_CYCLES = 64,
    parameter int CAL_TIMEOUT = 16777216,
    parameter int SYNC_STAGES = 2
) (
    input  logic               config_clk_clk,
    input  logic               config_reset_reset,
    input  logic               pcie_perst_n,
    input  logic               pll_locked,
    input  logic [NUM_MEM-1:0] mem_cal_success,
    input  logic [NUM_MEM-1:0] mem_cal_fail,
    input  logic               sw_reset_req,
    output logic               global_reset_n,
    output logic               mem_reset_n,
    output logic               kernel_reset_n,
    output logic [2:0]         status_state,
    output logic [1:0]         fault_code,
    output logic [7:0]         leds
);

    localparam int c_ASYNC_W = 3 + 2 * NUM_MEM;

    localparam logic [c_CNT_W-1:0] c_POR_LAST  = c_CNT_W'(POR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CAL_LAST  = c_CNT_W'(CAL_TIMEOUT - 1);

    logic [c_ASYNC_W-1:0] w_async;
    logic [c_ASYNC_W-1:0] w_async_s;
    logic                 w_pll_s;
    logic                 w_perst_n_s;
    logic [NUM_MEM-1:0]   w_success_s;
    logic [NUM_MEM-1:0]   w_fail_s;
    logic                 w_sw_s;
    logic                 w_sw_edge;
    logic                 w_link_lost;
    logic                 w_hb_led;

    state_e             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         fault_q, fault_d;
    logic               sw_prev_q;
    logic               glb_rst_n_q;
    logic               mem_rst_n_q;
    logic               krn_rst_n_q;

    assign w_async = {sw_reset_req, mem_cal_fail, mem_cal_success, pcie_perst_n, pll_locked};

    sync_bits #(
        .WIDTH  (c_ASYNC_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (config_clk_clk),
        .rst_i (config_reset_reset),
        .d_i   (w_async),
        .q_o   (w_async_s)
    );

    assign {w_sw_s, w_fail_s, w_success_s, w_perst_n_s, w_pll_s} = w_async_s;
    assign w_sw_edge   = w_sw_s & ~sw_prev_q;
    assign w_link_lost = ~w_pll_s | ~w_perst_n_s;

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            ST_POR_WAIT: begin
                if (cnt_q == c_POR_LAST) state_d = ST_PLL_WAIT;
            end
            ST_PLL_WAIT: begin
                if (w_pll_s && w_perst_n_s) state_d = ST_MEM_RST;
            end
            ST_MEM_RST: begin
                if (w_link_lost)               state_d = ST_PLL_WAIT;
                else if (cnt_q == c_HOLD_LAST) state_d = ST_CAL_WAIT;
            end
            ST_CAL_WAIT: begin
                if (w_link_lost) begin
                    state_d = ST_PLL_WAIT;
                end else if (w_sw_edge) begin
                    state_d = ST_MEM_RST;
                end else if (|w_fail_s) begin
                    state_d = ST_FAULT;
                    fault_d = c_FAULT_CAL_FAIL;
                end else if (&w_success_s) begin
                    state_d = ST_RUN;
                end else if (cnt_q == c_CAL_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = c_FAULT_CAL_TIMEOUT;
                end
            end
            ST_RUN: begin
                // RUN is only entered with every interface calibrated, so any low bit is a loss
                if (w_link_lost) begin
                    state_d = ST_PLL_WAIT;
                end else if (w_sw_edge) begin
                    state_d = ST_MEM_RST;
                end else if (!(&w_success_s)) begin
                    state_d = ST_FAULT;
                    fault_d = c_FAULT_CAL_LOST;
                end
            end
            ST_FAULT: begin
                if (w_link_lost)    state_d = ST_PLL_WAIT;
                else if (w_sw_edge) state_d = ST_MEM_RST;
            end
            default: begin
                state_d = ST_POR_WAIT;
            end
        endcase

        if (state_d != ST_FAULT) fault_d = c_FAULT_NONE;
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge config_clk_clk) begin
        if (config_reset_reset) begin
            state_q     <= ST_POR_WAIT;
            cnt_q       <= '0;
            fault_q     <= c_FAULT_NONE;
            sw_prev_q   <= 1'b0;
            glb_rst_n_q <= 1'b0;
            mem_rst_n_q <= 1'b0;
            krn_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            sw_prev_q   <= w_sw_s;
            glb_rst_n_q <= (state_d == ST_MEM_RST) || (state_d == ST_CAL_WAIT) ||
                           (state_d == ST_RUN)     || (state_d == ST_FAULT);
            mem_rst_n_q <= (state_d == ST_CAL_WAIT) || (state_d == ST_RUN);
            krn_rst_n_q <= (state_d == ST_RUN);
        end
    end

`ifdef BOARD_RESET_HEARTBEAT_EN
    logic [c_HB_W-1:0] hb_cnt_q;
    logic              hb_led_q;

    always_ff @(posedge config_clk_clk) begin
        if (config_reset_reset) begin
            hb_cnt_q <= '0;
            hb_led_q <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
            if (state_d != ST_RUN)  hb_led_q <= 1'b0;
            else if (&hb_cnt_q)     hb_led_q <= ~hb_led_q;
        end
    end

    assign w_hb_led = hb_led_q;
`else
    assign w_hb_led = 1'b0;
`endif

    always_comb begin
        leds = '0;
        leds[c_LED_STATE_MSB:c_LED_STATE_LSB] = state_q;
        leds[c_LED_PLL]       = w_pll_s;
        leds[c_LED_CAL_OK]    = &w_success_s;
        leds[c_LED_CAL_FAIL]  = |w_fail_s;
        leds[c_LED_FAULT]     = (state_q == ST_FAULT);
        leds[c_LED_HEARTBEAT] = w_hb_led;
    end

    assign status_state   = state_q;
    assign fault_code     = fault_q;
    assign global_reset_n = glb_rst_n_q;
    assign mem_reset_n    = mem_rst_n_q;
    assign kernel_reset_n = krn_rst_n_q;

endmodule

`default_nettype wire
